// File: rtl/keypad_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : keypad_scan                                                  |
// | Function : 4x4 active-low matrix keypad scanner with frame debounce,   |
// |            ghost rejection and a 4-digit BCD entry register.           |
// | Options  : define KEYPAD_REPEAT_EN to enable held-key auto-repeat.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEB_FRAMES   = 3,
  parameter int REPEAT_DELAY = 125,
  parameter int REPEAT_RATE  = 25
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  COL,
  output logic [3:0]  ROW,
  output logic [3:0]  KEY,
  output logic        VALID,
  output logic        HELD,
  output logic [15:0] DIG
);

  localparam int                  c_slot_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SCAN_DIV - 1);
  localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);
  localparam logic [3:0]          c_deb       = 4'(DEB_FRAMES);

  // Frame result encoding: {class[1:0], idx[3:0]}; idx is zero unless SINGLE
  localparam logic [1:0] c_cls_none   = 2'd0;
  localparam logic [1:0] c_cls_single = 2'd1;
  localparam logic [1:0] c_cls_multi  = 2'd2;

  logic [3:0]          r_col_s1;
  logic [3:0]          r_col_s2;
  logic [c_slot_w-1:0] r_slot;
  logic [1:0]          r_row;
  logic [3:0]          r_res0;
  logic [3:0]          r_res1;
  logic [3:0]          r_res2;
  logic [5:0]          r_cand;
  logic [3:0]          r_stab;
  logic [3:0]          r_key;
  logic                r_valid;
  logic                r_held;
  logic [15:0]         r_dig;

  logic                w_slot_end;
  logic                w_frame_end;
  logic [15:0]         w_act;
  logic [4:0]          w_ones;
  logic [3:0]          w_sidx;
  logic [5:0]          w_res;
  logic                w_same;
  logic [3:0]          w_stab_next;
  logic                w_accept;
  logic [3:0]          w_res_key;
  logic                w_rep_fire;

  // Map a scan index {row, col} to the key legend value
  function automatic logic [3:0] f_key(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:    v = 4'h1;
      4'd1:    v = 4'h2;
      4'd2:    v = 4'h3;
      4'd3:    v = 4'hA;
      4'd4:    v = 4'h4;
      4'd5:    v = 4'h5;
      4'd6:    v = 4'h6;
      4'd7:    v = 4'hB;
      4'd8:    v = 4'h7;
      4'd9:    v = 4'h8;
      4'd10:   v = 4'h9;
      4'd11:   v = 4'hC;
      4'd12:   v = 4'hE;
      4'd13:   v = 4'h0;
      4'd14:   v = 4'hF;
      default: v = 4'hD;
    endcase
    return v;
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_col_s1 <= '0;
      r_col_s2 <= '0;
    end else begin
      r_col_s1 <= COL;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_slot_end  = (r_slot == c_slot_last);
  assign w_frame_end = w_slot_end && (r_row == 2'd3);

  // Slot timer and row pointer; the row advances after each slot's last cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_slot <= '0;
      r_row  <= 2'd0;
    end else if (w_slot_end) begin
      r_slot <= '0;
      r_row  <= r_row + 2'd1;
    end else begin
      r_slot <= r_slot + c_slot_one;
    end
  end

  // Capture the synchronized columns for rows 0..2; row 3 is used live at frame end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_res0 <= 4'hF;
      r_res1 <= 4'hF;
      r_res2 <= 4'hF;
    end else if (w_slot_end) begin
      case (r_row)
        2'd0:    r_res0 <= r_col_s2;
        2'd1:    r_res1 <= r_col_s2;
        2'd2:    r_res2 <= r_col_s2;
        default: ;
      endcase
    end
  end

  // Active-high key matrix for the frame, bit index = {row, col}
  assign w_act = ~{r_col_s2, r_res2, r_res1, r_res0};

  // Classify the frame as NONE, SINGLE(idx) or MULTI
  always_comb begin
    w_ones = 5'd0;
    w_sidx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_act[i]) begin
        w_ones = w_ones + 5'd1;
        w_sidx = 4'(i);
      end
    end
    if (w_ones == 5'd0)
      w_res = {c_cls_none, 4'd0};
    else if (w_ones == 5'd1)
      w_res = {c_cls_single, w_sidx};
    else
      w_res = {c_cls_multi, 4'd0};
  end

  // Debounce bookkeeping: stability count of the current candidate and the accept strobe
  always_comb begin
    w_same      = (w_res == r_cand);
    w_stab_next = 4'd1;
    if (w_same)
      w_stab_next = (r_stab == 4'd15) ? 4'd15 : (r_stab + 4'd1);
    // Accept only on the frame where the count arrives at the threshold
    w_accept  = w_frame_end && (w_stab_next == c_deb) && (!w_same || (r_stab != c_deb));
    w_res_key = f_key(w_res[3:0]);
  end

  // Candidate and stability counter, updated once per frame
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cand <= {c_cls_none, 4'd0};
      r_stab <= 4'd0;
    end else if (w_frame_end) begin
      r_cand <= w_res;
      r_stab <= w_stab_next;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] c_rep_delay = 16'(REPEAT_DELAY);
  localparam logic [15:0] c_rep_rate  = 16'(REPEAT_RATE);

  logic [3:0]  r_acc_idx;
  logic [15:0] r_rep_cnt;
  logic        r_rep_first;
  logic [15:0] w_rep_cnt_n;
  logic        w_rep_track;

  // Repeat tracks only while the accepted key is still the debounce candidate
  always_comb begin
    w_rep_track = r_held && (w_res == {c_cls_single, r_acc_idx});
    w_rep_cnt_n = r_rep_cnt + 16'd1;
    w_rep_fire  = w_frame_end && !w_accept && w_rep_track &&
                  (r_rep_first ? (w_rep_cnt_n == c_rep_delay) : (w_rep_cnt_n == c_rep_rate));
  end

  // Frame counter since acceptance or since the previous repeat
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc_idx   <= 4'd0;
      r_rep_cnt   <= 16'd0;
      r_rep_first <= 1'b1;
    end else if (w_frame_end) begin
      if (w_accept && (w_res[5:4] == c_cls_single))
        r_acc_idx <= w_res[3:0];
      if (w_accept || !w_rep_track) begin
        r_rep_cnt   <= 16'd0;
        r_rep_first <= 1'b1;
      end else if (w_rep_fire) begin
        r_rep_cnt   <= 16'd0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt   <= w_rep_cnt_n;
      end
    end
  end
`else
  logic w_unused_rep;

  assign w_rep_fire   = 1'b0;
  assign w_unused_rep = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  // Accepted key state and the one-cycle VALID pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_key   <= 4'd0;
      r_held  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        if (w_res[5:4] == c_cls_single) begin
          r_key   <= w_res_key;
          r_held  <= 1'b1;
          r_valid <= 1'b1;
        end else if (w_res[5:4] == c_cls_none) begin
          r_held  <= 1'b0;
        end
      end else if (w_rep_fire) begin
        r_valid <= 1'b1;
      end
    end
  end

  // BCD entry register: digits shift in from the right, '#' clears
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dig <= 16'd0;
    end else if (r_valid) begin
      if (r_key <= 4'd9)
        r_dig <= {r_dig[11:0], r_key};
      else if (r_key == 4'hF)
        r_dig <= 16'd0;
    end
  end

  assign ROW   = ~(4'b0001 << r_row);
  assign KEY   = r_key;
  assign VALID = r_valid;
  assign HELD  = r_held;
  assign DIG   = r_dig;

endmodule
`default_nettype wire
